adder_result_checker: RTL

//   Response side of the adder stimulus sweep: samples each applied vector {a,b,cin}

---
 rtl/adder_result_checker.sv | 111 +++++++++++
 1 files changed

// File: rtl/adder_result_checker.sv
// Response checker for an adder stimulus sweep. Each sampled vector's DUT
// result is compared with a golden a+b+cin. The block counts vectors and
// failures, keeps the first failing vector, and reports done/pass once the
// programmed number of vectors has been checked.
module adder_result_checker #(
   parameter int WIDTH       = 4,
   parameter int NUM_VECTORS = 512,
   parameter int CNT_W       = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic             in_cin,
   input  logic [WIDTH-1:0] dut_sum,
   input  logic             dut_carry,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic             mismatch,
   output logic [CNT_W-1:0] vec_count,
   output logic [CNT_W-1:0] err_count,
   output logic             ff_valid,
   output logic [WIDTH-1:0] ff_a,
   output logic [WIDTH-1:0] ff_b,
   output logic             ff_cin,
   output logic [WIDTH-1:0] ff_sum,
   output logic             ff_carry
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   // vec_count value just before the final vector of a run is sampled
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_VECTORS - 1);

   state_t           state, state_nxt;
   logic [WIDTH:0]   exp_res;
   logic             fail;
   logic             sample;
   logic             last;

   assign exp_res = {1'b0, in_a} + {1'b0, in_b} + {{WIDTH{1'b0}}, in_cin};
   assign fail    = ({dut_carry, dut_sum} != exp_res);
   // start has priority: a vector presented alongside start is dropped
   assign sample  = (state == RUN) && in_valid && !start;
   assign last    = sample && (vec_count == LAST_CNT);

   assign busy = (state == RUN);
   assign done = (state == DONE);
   assign pass = done && (err_count == '0);

   // state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // next-state: any start (re)enters RUN; the final sample enters DONE
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = RUN;
         RUN:     if (start) state_nxt = RUN;
                  else if (last) state_nxt = DONE;
         DONE:    if (start) state_nxt = RUN;
         default: state_nxt = IDLE;
      endcase
   end

   // counters, mismatch pulse and first-fail capture
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mismatch  <= 1'b0;
         vec_count <= '0;
         err_count <= '0;
         ff_valid  <= 1'b0;
         ff_a      <= '0;
         ff_b      <= '0;
         ff_cin    <= 1'b0;
         ff_sum    <= '0;
         ff_carry  <= 1'b0;
      end else if (start) begin
         mismatch  <= 1'b0;
         vec_count <= '0;
         err_count <= '0;
         ff_valid  <= 1'b0;
         ff_a      <= '0;
         ff_b      <= '0;
         ff_cin    <= 1'b0;
         ff_sum    <= '0;
         ff_carry  <= 1'b0;
      end else begin
         mismatch <= sample && fail;
         if (sample) vec_count <= vec_count + 1'b1;
         if (sample && fail) begin
            if (err_count != '1) err_count <= err_count + 1'b1;
            if (!ff_valid) begin
               ff_valid <= 1'b1;
               ff_a     <= in_a;
               ff_b     <= in_b;
               ff_cin   <= in_cin;
               ff_sum   <= dut_sum;
               ff_carry <= dut_carry;
            end
         end
      end
   end

endmodule
